// File: rtl/vga_timing_gen.sv
// Raster timing generator: hsync, vsync, de, pixel coordinates and
// line/frame pulses, all registered and aligned one cycle behind the counters.
module vga_timing_gen #(
   parameter int H_ACTIVE = 1920,
   parameter int H_FP     = 88,
   parameter int H_SYNC   = 44,
   parameter int H_BP     = 148,
   parameter int V_ACTIVE = 1080,
   parameter int V_FP     = 4,
   parameter int V_SYNC   = 5,
   parameter int V_BP     = 36,
   parameter int H_POL    = 1,
   parameter int V_POL    = 1,
   parameter int CW       = 12
) (
   input  logic          clk_pix,
   input  logic          rstn,
   input  logic          en,
   output logic          hsync,
   output logic          vsync,
   output logic          de,
   output logic [CW-1:0] x,
   output logic [CW-1:0] y,
   output logic          frame_start,
   output logic          line_start
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
   localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
   localparam logic [CW-1:0] H_ACT  = CW'(H_ACTIVE);
   localparam logic [CW-1:0] V_ACT  = CW'(V_ACTIVE);
   localparam logic [CW-1:0] HS_BEG = CW'(H_ACTIVE + H_FP);
   localparam logic [CW-1:0] HS_END = CW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CW-1:0] VS_BEG = CW'(V_ACTIVE + V_FP);
   localparam logic [CW-1:0] VS_END = CW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic          HPOL   = (H_POL != 0);
   localparam logic          VPOL   = (V_POL != 0);

   logic [CW-1:0] h_q, h_d;
   logic [CW-1:0] v_q, v_d;

   logic          hs_q, hs_d;
   logic          vs_q, vs_d;
   logic          de_q, de_d;
   logic [CW-1:0] x_q;
   logic [CW-1:0] y_q;
   logic          fs_q, fs_d;
   logic          ls_q, ls_d;

   // Next raster position: wrap the line, then the frame.
   always_comb begin
      h_d = h_q + CW'(1);
      v_d = v_q;
      if (h_q == H_LAST) begin
         h_d = '0;
         v_d = (v_q == V_LAST) ? '0 : v_q + CW'(1);
      end
   end

   // Decode the current (pre-increment) position into output levels.
   always_comb begin
      de_d = (h_q < H_ACT) && (v_q < V_ACT);
      hs_d = ((h_q >= HS_BEG) && (h_q < HS_END)) ? HPOL : ~HPOL;
      vs_d = ((v_q >= VS_BEG) && (v_q < VS_END)) ? VPOL : ~VPOL;
      ls_d = (h_q == '0);
      fs_d = (h_q == '0) && (v_q == '0);
   end

   // Raster counters advance only while enabled.
   always_ff @(posedge clk_pix or negedge rstn) begin
      if (!rstn) begin
         h_q <= '0;
         v_q <= '0;
      end else if (en) begin
         h_q <= h_d;
         v_q <= v_d;
      end
   end

   // Output registers; pulses drop while frozen so none is repeated.
   always_ff @(posedge clk_pix or negedge rstn) begin
      if (!rstn) begin
         hs_q <= ~HPOL;
         vs_q <= ~VPOL;
         de_q <= 1'b0;
         x_q  <= '0;
         y_q  <= '0;
         fs_q <= 1'b0;
         ls_q <= 1'b0;
      end else if (en) begin
         hs_q <= hs_d;
         vs_q <= vs_d;
         de_q <= de_d;
         x_q  <= h_q;
         y_q  <= v_q;
         fs_q <= fs_d;
         ls_q <= ls_d;
      end else begin
         fs_q <= 1'b0;
         ls_q <= 1'b0;
      end
   end

   assign hsync       = hs_q;
   assign vsync       = vs_q;
   assign de          = de_q;
   assign x           = x_q;
   assign y           = y_q;
   assign frame_start = fs_q;
   assign line_start  = ls_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen on a reduced 14x7 raster, with
// random enable gating and asynchronous mid-frame reset.
module tb_vga_timing_gen;

   localparam int HA = 8, HFP = 2, HSW = 2, HBP = 2;
   localparam int VA = 4, VFP = 1, VSW = 1, VBP = 1;
   localparam int CW = 12;
   localparam int HT = HA + HFP + HSW + HBP;
   localparam int VT = VA + VFP + VSW + VBP;
   localparam int FT = HT * VT;

   typedef struct packed {
      logic          hs;
      logic          vs;
      logic          de;
      logic [CW-1:0] x;
      logic [CW-1:0] y;
      logic          fs;
      logic          ls;
   } obs_t;

   logic          clk_pix = 1'b0;
   logic          rstn    = 1'b0;
   logic          en      = 1'b0;
   logic          hsync, vsync, de, frame_start, line_start;
   logic [CW-1:0] x, y;

   vga_timing_gen #(
      .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
      .H_POL(1), .V_POL(1), .CW(CW)
   ) dut (
      .clk_pix(clk_pix), .rstn(rstn), .en(en),
      .hsync(hsync), .vsync(vsync), .de(de),
      .x(x), .y(y),
      .frame_start(frame_start), .line_start(line_start)
   );

   always #5 clk_pix = ~clk_pix;

   int   checks = 0;
   int   errors = 0;
   obs_t expq[$];
   obs_t last;
   int   pnext;

   localparam obs_t RST_OBS = '0;

   function automatic obs_t dut_obs();
      obs_t o;
      o.hs = hsync; o.vs = vsync; o.de = de;
      o.x = x; o.y = y;
      o.fs = frame_start; o.ls = line_start;
      return o;
   endfunction

   // Reference: a pixel is a linear index into the frame.
   function automatic obs_t ref_pix(int p);
      obs_t o;
      int h, v;
      h = p % HT;
      v = p / HT;
      o.de = (h < HA) && (v < VA);
      o.hs = (h >= HA + HFP) && (h < HA + HFP + HSW);
      o.vs = (v >= VA + VFP) && (v < VA + VFP + VSW);
      o.x  = CW'(h);
      o.y  = CW'(v);
      o.fs = (p == 0);
      o.ls = (h == 0);
      return o;
   endfunction

   task automatic model_reset();
      pnext = 0;
      last  = RST_OBS;
   endtask

   task automatic step(input bit e, input bit rel);
      @(negedge clk_pix);
      if (rel) rstn = 1'b1;
      en = e;
      if (e) begin
         last  = ref_pix(pnext);
         pnext = (pnext + 1) % FT;
      end else begin
         last.fs = 1'b0;
         last.ls = 1'b0;
      end
      expq.push_back(last);
   endtask

   task automatic direct_check(input string name, input obs_t want);
      obs_t got;
      got = dut_obs();
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got=%h want=%h", name, got, want);
      end
   endtask

   // Monitor: compare each registered output against the queued expectation.
   initial begin
      obs_t got, want;
      forever begin
         @(posedge clk_pix);
         #1;
         if (expq.size() > 0) begin
            want = expq.pop_front();
            got  = dut_obs();
            checks++;
            if (got !== want) begin
               errors++;
               $display("FAIL cycle t=%0t got=%h want=%h", $time, got, want);
            end
         end
      end
   end

   initial begin
      model_reset();
      repeat (3) @(negedge clk_pix);
      direct_check("reset_hold", RST_OBS);

      // Release with en high; the first cycle must show (0,0).
      step(1'b1, 1'b1);
      repeat (3 * FT) step(1'b1, 1'b0);

      // Freeze at x=5, y=2 and resume.
      while (pnext != 2 * HT + 5) step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      repeat (10) step(1'b0, 1'b0);
      repeat (FT) step(1'b1, 1'b0);

      // Freeze right after a line_start and after a frame_start.
      while (pnext != 1) step(1'b1, 1'b0);
      repeat (4) step(1'b0, 1'b0);
      while (pnext != HT + 1) step(1'b1, 1'b0);
      repeat (4) step(1'b0, 1'b0);

      // Random enable pattern over several frames.
      repeat (4 * FT) step(($urandom_range(0, 3) != 0), 1'b0);

      // Asynchronous reset mid-frame at x=9, y=3.
      while (pnext != 3 * HT + 9) step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      @(negedge clk_pix);
      en = 1'b1;
      #2;
      rstn = 1'b0;
      #1;
      direct_check("async_reset", RST_OBS);
      model_reset();
      repeat (2) @(negedge clk_pix);
      direct_check("reset_low", RST_OBS);
      step(1'b1, 1'b1);
      repeat (2 * FT) step(1'b1, 1'b0);

      repeat (3) @(negedge clk_pix);
      checks++;
      if (expq.size() != 0) begin
         errors++;
         $display("FAIL drain left=%0d want=0", expq.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
